// File: rtl/powlib_pkg.sv
// Shared width helpers and lane index/amount types for the mfifo slice.
// Latency: none (compile-time functions and types only).
// Backpressure: not applicable.
package powlib_pkg;

    typedef int unsigned lane_idx_t;   // lane number, 0..CHANNELS-1
    typedef int unsigned amount_t;     // depths, counts and bit widths

    // Pointer width; a depth of 1 still needs one bit.
    function automatic amount_t ptr_w(input amount_t depth);
        return (depth > 1) ? amount_t'($clog2(depth)) : 1;
    endfunction

    // Fill-count width: one extra bit so that "full" (== depth) fits.
    function automatic amount_t lvl_w(input amount_t depth);
        return amount_t'($clog2(depth)) + 1;
    endfunction

    // Lane-index width; a single lane still gets a one-bit index.
    function automatic amount_t idx_w(input amount_t channels);
        return (channels > 1) ? amount_t'($clog2(channels)) : 1;
    endfunction

endpackage

// File: rtl/mfifo_lane.sv
// One mfifo lane: circular buffer with write/read pointers, fill level and flush.
// Latency: written entry visible on head_dat_o the cycle after the write edge.
// Backpressure: wr_rdy_o drops when full; writes to a full lane are ignored.
module mfifo_lane
    import powlib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush_i,
    input  logic                           wr_vld_i,
    input  logic [WIDTH-1:0]               wr_dat_i,
    input  logic                           rd_en_i,
    output logic                           wr_rdy_o,
    output logic                           empty_o,
    output logic [WIDTH-1:0]               head_dat_o,
    output logic [int'(lvl_w(DEPTH))-1:0]  level_o
);

    localparam int              PW       = int'(ptr_w(DEPTH));
    localparam int              LW       = int'(lvl_w(DEPTH));
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_fire, rd_fire;

    assign wr_rdy_o   = (level_q != FULL_LVL);
    assign empty_o    = (level_q == '0);
    // A flush drops any same-cycle write or read on this lane.
    assign wr_fire    = wr_vld_i && wr_rdy_o && !flush_i;
    assign rd_fire    = rd_en_i && !empty_o && !flush_i;
    // Unregistered read port straight into the output register upstream.
    assign head_dat_o = mem_q[rptr_q];
    assign level_o    = level_q;

    // Next pointers and fill level: flush clears, otherwise advance with wrap.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_fire) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
            if (rd_fire) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array, deliberately not reset so it maps onto distributed RAM.
    always_ff @(posedge clock) begin
        if (wr_fire) mem_q[wptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/mfifo.sv
// Multi-lane FIFO: CHANNELS lanes merged round-robin into one output register.
// Latency: one cycle from write edge to out_valid at the earliest (no bypass).
// Backpressure: per-lane in_ready when not full; out_ready stalls the output register.
module mfifo
    import powlib_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int CHANNELS = 4,
    parameter int RESERVED = 0
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [CHANNELS-1:0]                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0]                in_data,
    output logic [CHANNELS-1:0]                      in_ready,
    input  logic [CHANNELS-1:0]                      flush,
    output logic [CHANNELS-1:0]                      available,
    output logic [CHANNELS*int'(lvl_w(DEPTH))-1:0]   level,
    output logic                                     out_valid,
    output logic [WIDTH-1:0]                         out_data,
    output logic [int'(idx_w(CHANNELS))-1:0]         out_channel,
    input  logic                                     out_ready
);

    localparam int            LW        = int'(lvl_w(DEPTH));
    localparam int            IW        = int'(idx_w(CHANNELS));
    localparam logic [LW-1:0] AVAIL_LIM = LW'(DEPTH - RESERVED);

    logic [WIDTH-1:0]    head_dat [CHANNELS];
    logic [CHANNELS-1:0] lane_rdy, lane_empty, rd_en, eligible;
    logic [IW-1:0]       grant;
    logic                any_elig, load;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [IW-1:0]       out_channel_q, out_channel_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        mfifo_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .flush_i    (flush[i]),
            .wr_vld_i   (in_valid[i]),
            .wr_dat_i   (in_data[i*WIDTH +: WIDTH]),
            .rd_en_i    (rd_en[i]),
            .wr_rdy_o   (lane_rdy[i]),
            .empty_o    (lane_empty[i]),
            .head_dat_o (head_dat[i]),
            .level_o    (level[i*LW +: LW])
        );
        // Lanes are emptied by reset, so report ready throughout it.
        assign in_ready[i]  = reset || lane_rdy[i];
        assign available[i] = (level[i*LW +: LW] < AVAIL_LIM);
    end

    // A lane being flushed this cycle must not win the output register.
    assign eligible = ~lane_empty & ~flush;
    assign any_elig = |eligible;
    assign load     = (!out_valid_q || out_ready) && any_elig;
    assign rd_en    = load ? (CHANNELS'(1) << grant) : '0;

    // Round-robin arbiter: rotate so bit 0 is last_grant+1, take first set bit.
    always_comb begin
        logic [2*CHANNELS-1:0] dbl;
        logic [CHANNELS-1:0]   rot;
        logic                  found;
        grant = last_grant_q;
        found = 1'b0;
        dbl   = {eligible, eligible} >> (int'(last_grant_q) + 1);
        rot   = dbl[CHANNELS-1:0];
        for (int p = 0; p < CHANNELS; p++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                grant = IW'((int'(last_grant_q) + 1 + p) % CHANNELS);
            end
            rot = rot >> 1;
        end
    end

    // Output register: load on grant, else drain on out_ready, else hold.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        last_grant_d  = last_grant_q;
        if (load) begin
            out_valid_d   = 1'b1;
            out_data_d    = head_dat[grant];
            out_channel_d = grant;
            last_grant_d  = grant;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    // Output and arbiter state; last_grant resets so lane 0 wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            last_grant_q  <= IW'(CHANNELS - 1);
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_mfifo.sv
module tb_mfifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CH = 4;
    localparam int LW = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [CH-1:0]     in_valid;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     in_ready;
    logic [CH-1:0]     flush;
    logic [CH-1:0]     available;
    logic [CH*LW-1:0]  level;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [1:0]        out_channel;
    logic              out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];
    logic       prev_hold;
    logic [7:0] prev_data;

    mfifo #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .RESERVED(1)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .available   (available),
        .level       (level),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_channel (out_channel),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] d);
        in_data = (in_data & ~(32'hFF << (8*i))) | (32'(d) << (8*i));
    endtask

    function automatic logic [2:0] lvl(input int i);
        logic [11:0] l;
        l = level >> (LW*i);
        return l[2:0];
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; flush = '0; out_ready = 1'b0; in_data = '0;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_channel", out_channel, 0);
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 4'hF);
        chk("rst_available", available, 4'hF);

        // Test 1: lane 2 stream A0..A3, out_ready=1, first output one edge after write
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            set_lane(2, 8'hA0 + 8'(k));
            step();
            if (k == 0) chk("t1_no_bypass", out_valid, 0);
            else begin
                chk("t1_valid", out_valid, 1);
                chk("t1_data", out_data, 8'hA0 + 8'(k - 1));
                chk("t1_chan", out_channel, 2);
            end
        end
        in_valid = '0;
        step();
        chk("t1_last_data", out_data, 8'hA3);
        chk("t1_last_chan", out_channel, 2);
        step();
        chk("t1_drained", out_valid, 0);

        // Test 2: output register occupied by D0, then fill lane 0 to full
        do_reset();
        in_valid = 4'b1000; set_lane(3, 8'hD0);
        step();
        in_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 8'hB0 + 8'(k));
            step();
            if (k == 1) chk("t2_avail_lvl2", available[0], 1);
            if (k == 2) begin
                chk("t2_avail_lvl3", available[0], 0);
                chk("t2_rdy_lvl3", in_ready[0], 1);
            end
        end
        chk("t2_full_rdy", in_ready[0], 0);
        chk("t2_full_lvl", lvl(0), 4);
        set_lane(0, 8'hB4);
        step();
        chk("t2_ignored_lvl", lvl(0), 4);
        chk("t2_hold_data", out_data, 8'hD0);
        chk("t2_hold_chan", out_channel, 3);
        in_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_drain_valid", out_valid, 1);
            chk("t2_drain_data", out_data, 8'hB0 + 8'(k));
            chk("t2_drain_chan", out_channel, 0);
        end
        step();
        chk("t2_drain_end", out_valid, 0);
        chk("t2_drain_lvl", level, 0);

        // Test 3: lanes 0,1,3 hold two entries each -> 0,1,3,0,1,3
        do_reset();
        in_valid = 4'b1011;
        set_lane(0, 8'hC0); set_lane(1, 8'hD0); set_lane(3, 8'hF0);
        step();
        set_lane(0, 8'hC1); set_lane(1, 8'hD1); set_lane(3, 8'hF1);
        step();
        in_valid = '0; out_ready = 1'b1;
        begin
            logic [1:0] ch_seq [6];
            logic [7:0] dt_seq [6];
            ch_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
            dt_seq = '{8'hC0, 8'hD0, 8'hF0, 8'hC1, 8'hD1, 8'hF1};
            for (int k = 0; k < 6; k++) begin
                chk("t3_chan", out_channel, ch_seq[k]);
                chk("t3_data", out_data, dt_seq[k]);
                step();
            end
        end
        chk("t3_end", out_valid, 0);

        // Test 4: flush lane 1 (3 entries) with a same-cycle write
        out_ready = 1'b0;
        in_valid = 4'b0100; set_lane(2, 8'hE0);
        step();
        in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            set_lane(1, 8'h11 + 8'(k));
            step();
        end
        chk("t4_pre_lvl", lvl(1), 3);
        chk("t4_pre_data", out_data, 8'hE0);
        flush = 4'b0010; set_lane(1, 8'h14);
        step();
        flush = '0; in_valid = '0;
        chk("t4_flush_lvl", lvl(1), 0);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_out_data", out_data, 8'hE0);
        chk("t4_out_chan", out_channel, 2);
        out_ready = 1'b1;
        step();
        chk("t4_no_lane1", out_valid, 0);
        step();
        chk("t4_no_lane1_b", out_valid, 0);

        // Test 5: all lanes loaded, out_ready toggling
        do_reset();
        in_valid = 4'b1111;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 4; i++) set_lane(i, 8'h50 + 8'(16*i + j));
            step();
        end
        in_valid = '0;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) exp_q.push_back(8'h50 + 8'(16*i + j));
        for (int c = 0; c < 20; c++) begin
            out_ready = (c % 2 == 0);
            if (out_valid && out_ready) chk("t5_data", out_data, exp_q.pop_front());
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            step();
            if (prev_hold) chk("t5_hold", out_data, prev_data);
        end
        chk("t5_remaining", exp_q.size(), 0);
        chk("t5_end", out_valid, 0);

        // Test 6: reset mid-stream
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) set_lane(i, 8'h60 + 8'(16*i + k));
            step();
        end
        chk("t6_lvl3", lvl(0), 3);
        chk("t6_avail0", available[0], 0);
        chk("t6_rdy0", in_ready[0], 1);
        chk("t6_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6_rdy_during", in_ready, 4'hF);
        step();
        chk("t6_valid", out_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_rdy_after", in_ready, 4'hF);
        reset = 1'b0; in_valid = '0;
        step();
        chk("t6_level_b", level, 0);
        chk("t6_valid_b", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
